// File: rtl/glyph_text_renderer.sv
// Font ROM reader: renders a double-buffered glyph string at a latched screen position.
// Free-running 3-stage pipeline from the pixel counters to pixel_out/active_out.
module glyph_text_renderer #(
  parameter int unsigned NUM_CHARS  = 8,
  parameter int unsigned SCALE_LOG2 = 0,
  localparam int unsigned SLOT_W    = $clog2(NUM_CHARS)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic [10:0]       x_in,
  input  logic [9:0]        y_in,
  input  logic              wr_en_in,
  input  logic [SLOT_W-1:0] wr_idx_in,
  input  logic [4:0]        wr_code_in,
  output logic [8:0]        rom_addr_out,
  input  logic [15:0]       rom_data_in,
  output logic              pixel_out,
  output logic              active_out
);

  localparam int unsigned BOX_W      = (NUM_CHARS * 16) << SCALE_LOG2;
  localparam int unsigned BOX_H      = 16 << SCALE_LOG2;
  localparam logic [4:0]  CODE_BLANK = 5'd16;
  localparam logic [4:0]  CODE_MAX   = 5'd17;

  logic [4:0]        r_pending [NUM_CHARS];
  logic [4:0]        r_shadow  [NUM_CHARS];
  logic [10:0]       r_x_lat;
  logic [9:0]        r_y_lat;
  logic [8:0]        r_rom_addr;
  logic [3:0]        r_bitsel1;
  logic [3:0]        r_bitsel2;
  logic              r_hit1;
  logic              r_hit2;
  logic              r_pixel;
  logic              r_active;

  logic              w_frame_start;
  logic [11:0]       w_x_end;
  logic [10:0]       w_y_end;
  logic              w_hit;
  logic [10:0]       w_dx_full;
  logic [9:0]        w_dy_full;
  logic [SLOT_W+3:0] w_dx;
  logic [3:0]        w_row;
  logic [SLOT_W-1:0] w_slot;
  logic [4:0]        w_code_raw;
  logic [4:0]        w_code;
  logic [8:0]        w_addr;
  logic [3:0]        w_bitsel;

  assign w_frame_start = (hcount_in == 11'd0) && (vcount_in == 10'd0);

  // Box ends are one bit wider than the counters so boxes clip at the screen edge.
  assign w_x_end = {1'b0, r_x_lat} + 12'(BOX_W);
  assign w_y_end = {1'b0, r_y_lat} + 11'(BOX_H);
  assign w_hit   = (hcount_in >= r_x_lat) && ({1'b0, hcount_in} < w_x_end) &&
                   (vcount_in >= r_y_lat) && ({1'b0, vcount_in} < w_y_end);

  assign w_dx_full  = hcount_in - r_x_lat;
  assign w_dy_full  = vcount_in - r_y_lat;
  assign w_dx       = (SLOT_W+4)'(w_dx_full >> SCALE_LOG2);
  assign w_row      = 4'(w_dy_full >> SCALE_LOG2);
  assign w_slot     = w_dx[SLOT_W+3:4];
  assign w_code_raw = r_shadow[w_slot];
  assign w_code     = (!w_hit || (w_code_raw > CODE_MAX)) ? CODE_BLANK : w_code_raw;
  assign w_addr     = {w_code, 4'b0000} + {5'b00000, w_row};
  assign w_bitsel   = 4'd15 - w_dx[3:0];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < int'(NUM_CHARS); i++) r_pending[i] <= CODE_BLANK;
    end else if (wr_en_in) begin
      r_pending[wr_idx_in] <= wr_code_in;
    end
  end

  // Shadow string and position only change at frame start, so a frame never tears.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < int'(NUM_CHARS); i++) r_shadow[i] <= CODE_BLANK;
      r_x_lat <= 11'd0;
      r_y_lat <= 10'd0;
    end else if (w_frame_start) begin
      for (int i = 0; i < int'(NUM_CHARS); i++) r_shadow[i] <= r_pending[i];
      r_x_lat <= x_in;
      r_y_lat <= y_in;
    end
  end

  // Stage 1 drives the ROM address; stage 2 waits out the ROM latency; stage 3 picks the bit.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rom_addr <= 9'd0;
      r_bitsel1  <= 4'd0;
      r_hit1     <= 1'b0;
      r_bitsel2  <= 4'd0;
      r_hit2     <= 1'b0;
      r_pixel    <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_rom_addr <= w_addr;
      r_bitsel1  <= w_bitsel;
      r_hit1     <= w_hit;
      r_bitsel2  <= r_bitsel1;
      r_hit2     <= r_hit1;
      r_pixel    <= r_hit2 & rom_data_in[r_bitsel2];
      r_active   <= r_hit2;
    end
  end

  assign rom_addr_out = r_rom_addr;
  assign pixel_out    = r_pixel;
  assign active_out   = r_active;

endmodule

// File: tb/tb_glyph_text_renderer.sv
// Bench for glyph_text_renderer: two instances (scale 1x and 2x) on shared stimulus,
// each fed by a 1-cycle font ROM and checked against a per-pixel reference model.
module tb_glyph_text_renderer;

  localparam int NC = 8;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic        wr_en_in;
  logic [2:0]  wr_idx_in;
  logic [4:0]  wr_code_in;
  logic [8:0]  addr0, addr1;
  logic [15:0] rom_d0, rom_d1;
  logic        pix0, pix1, act0, act1;

  logic [15:0] rom_tbl [512];

  int          pend [NC];
  int          shad [NC];
  int          xl, yl;
  logic        pp0 [3], pa0 [3], pp1 [3], pa1 [3];
  logic [8:0]  e_addr0, e_addr1;
  logic        e_pix0, e_pix1, e_act0, e_act1;
  int          vecs = 0;
  int          miss = 0;

  always #5 clk_in = ~clk_in;

  glyph_text_renderer #(.NUM_CHARS(NC), .SCALE_LOG2(0)) u_dut0 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .x_in(x_in), .y_in(y_in), .wr_en_in(wr_en_in), .wr_idx_in(wr_idx_in),
    .wr_code_in(wr_code_in), .rom_addr_out(addr0), .rom_data_in(rom_d0),
    .pixel_out(pix0), .active_out(act0)
  );

  glyph_text_renderer #(.NUM_CHARS(NC), .SCALE_LOG2(1)) u_dut1 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .x_in(x_in), .y_in(y_in), .wr_en_in(wr_en_in), .wr_idx_in(wr_idx_in),
    .wr_code_in(wr_code_in), .rom_addr_out(addr1), .rom_data_in(rom_d1),
    .pixel_out(pix1), .active_out(act1)
  );

  // Font ROM with one cycle of read latency
  always @(posedge clk_in) begin
    rom_d0 <= rom_tbl[addr0];
    rom_d1 <= rom_tbl[addr1];
  end

  // Expected outputs for one pixel position, from the box/slot/row rules
  task automatic model_out(input int s, input int h, input int v,
                           output logic [8:0] addr, output logic pix, output logic act);
    int w, ht, col, row, code, bitn;
    w    = (NC * 16) << s;
    ht   = 16 << s;
    act  = (h >= xl) && (h < xl + w) && (v >= yl) && (v < yl + ht);
    row  = (((v - yl) & 1023) >> s) & 15;
    code = 16;
    bitn = 0;
    if (act) begin
      col  = (h - xl) >> s;
      code = shad[col / 16];
      if (code > 17) code = 16;
      bitn = 15 - (col % 16);
    end
    addr = 9'(code * 16 + row);
    pix  = act && rom_tbl[addr][bitn];
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      pend[i] = 16;
      shad[i] = 16;
    end
    xl = 0;
    yl = 0;
    for (int i = 0; i < 3; i++) begin
      pp0[i] = 1'b0; pa0[i] = 1'b0; pp1[i] = 1'b0; pa1[i] = 1'b0;
    end
    e_addr0 = 9'd0; e_addr1 = 9'd0;
    e_pix0 = 1'b0; e_pix1 = 1'b0; e_act0 = 1'b0; e_act1 = 1'b0;
  endtask

  // Apply one counter position for one clock and advance the model by one edge
  task automatic step(input int h, input int v);
    logic [8:0] a0, a1;
    logic       p0, p1, c0, c1;
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    model_out(0, h, v, a0, p0, c0);
    model_out(1, h, v, a1, p1, c1);
    @(posedge clk_in);
    #1;
    for (int i = 2; i > 0; i--) begin
      pp0[i] = pp0[i-1]; pa0[i] = pa0[i-1]; pp1[i] = pp1[i-1]; pa1[i] = pa1[i-1];
    end
    pp0[0] = p0; pa0[0] = c0; pp1[0] = p1; pa1[0] = c1;
    e_addr0 = a0; e_addr1 = a1;
    e_pix0 = pp0[2]; e_act0 = pa0[2]; e_pix1 = pp1[2]; e_act1 = pa1[2];
    if (h == 0 && v == 0) begin
      for (int i = 0; i < NC; i++) shad[i] = pend[i];
      xl = int'(x_in);
      yl = int'(y_in);
    end
    if (wr_en_in) pend[wr_idx_in] = int'(wr_code_in);
    wr_en_in = 1'b0;
  endtask

  task automatic set_write(input int idx, input int code);
    wr_en_in   = 1'b1;
    wr_idx_in  = 3'(idx);
    wr_code_in = 5'(code);
  endtask

  task automatic test_reset();
    vecs++;
    if ({addr0, pix0, act0, addr1, pix1, act1} !== 24'd0) begin
      miss++;
      $display("FAIL reset: got a0=%0d p0=%b c0=%b a1=%0d p1=%b c1=%b, need all 0",
               addr0, pix0, act0, addr1, pix1, act1);
    end
  endtask

  task automatic test_blank_frame();
    x_in = 11'd100;
    y_in = 10'd50;
    step(0, 0);
    for (int v = 48; v <= 52; v++) begin
      for (int h = 96; h <= 240; h++) begin
        step(h, v);
        vecs++;
        if ({addr0, pix0, act0, addr1, pix1, act1} !==
            {e_addr0, e_pix0, e_act0, e_addr1, e_pix1, e_act1} ||
            addr0 < 9'd256 || addr0 > 9'd271) begin
          miss++;
          $display("FAIL blank h=%0d v=%0d: got %0d/%b/%b %0d/%b/%b need %0d/%b/%b %0d/%b/%b",
                   h, v, addr0, pix0, act0, addr1, pix1, act1,
                   e_addr0, e_pix0, e_act0, e_addr1, e_pix1, e_act1);
        end
      end
    end
  endtask

  task automatic test_glyph_a();
    logic [15:0] cap;
    cap = 16'h0000;
    set_write(0, 0);
    step(7, 9);
    x_in = 11'd100;
    y_in = 10'd50;
    step(0, 0);
    for (int v = 49; v <= 51; v++) begin
      for (int h = 96; h <= 136; h++) begin
        step(h, v);
        if (v == 50 && h >= 102 && h <= 117) cap[117 - h] = pix0;
        vecs++;
        if ({addr0, pix0, act0, addr1, pix1, act1} !==
            {e_addr0, e_pix0, e_act0, e_addr1, e_pix1, e_act1}) begin
          miss++;
          $display("FAIL glyph_a h=%0d v=%0d: got %0d/%b/%b %0d/%b/%b need %0d/%b/%b %0d/%b/%b",
                   h, v, addr0, pix0, act0, addr1, pix1, act1,
                   e_addr0, e_pix0, e_act0, e_addr1, e_pix1, e_act1);
        end
        if (v == 50 && h >= 100 && h <= 115) begin
          vecs++;
          if (addr0 !== 9'd0) begin
            miss++;
            $display("FAIL glyph_a_addr h=%0d: got %0d need 0", h, addr0);
          end
        end
      end
    end
    vecs++;
    if (cap !== 16'b0000011111100000) begin
      miss++;
      $display("FAIL glyph_a_row: got %b need 0000011111100000", cap);
    end
  endtask

  task automatic test_commit();
    logic [8:0] want;
    set_write(0, 8);
    step(10, 60);
    for (int pass = 0; pass < 3; pass++) begin
      // pass 0: same frame; pass 1: frame start carries a write; pass 2: the frame after
      if (pass == 1) set_write(0, 3);
      if (pass > 0) step(0, 0);
      want = (pass == 0) ? 9'd0 : (pass == 1) ? 9'd128 : 9'd48;
      for (int h = 98; h <= 120; h++) begin
        step(h, 50);
        vecs++;
        if ({addr0, pix0, act0, addr1, pix1, act1} !==
            {e_addr0, e_pix0, e_act0, e_addr1, e_pix1, e_act1}) begin
          miss++;
          $display("FAIL commit%0d h=%0d: got %0d/%b/%b %0d/%b/%b need %0d/%b/%b %0d/%b/%b",
                   pass, h, addr0, pix0, act0, addr1, pix1, act1,
                   e_addr0, e_pix0, e_act0, e_addr1, e_pix1, e_act1);
        end
        if (h == 100) begin
          vecs++;
          if (addr0 !== want) begin
            miss++;
            $display("FAIL commit%0d_addr: got %0d need %0d", pass, addr0, want);
          end
        end
      end
    end
  endtask

  task automatic test_invalid_code();
    set_write(1, 25);
    step(20, 20);
    step(0, 0);
    for (int v = 50; v <= 53; v++) begin
      for (int h = 110; h <= 150; h++) begin
        step(h, v);
        vecs++;
        if ({addr0, pix0, act0, addr1, pix1, act1} !==
            {e_addr0, e_pix0, e_act0, e_addr1, e_pix1, e_act1}) begin
          miss++;
          $display("FAIL invalid h=%0d v=%0d: got %0d/%b/%b %0d/%b/%b need %0d/%b/%b %0d/%b/%b",
                   h, v, addr0, pix0, act0, addr1, pix1, act1,
                   e_addr0, e_pix0, e_act0, e_addr1, e_pix1, e_act1);
        end
        if (h == 120) begin
          vecs++;
          if (addr0 !== 9'(256 + v - 50)) begin
            miss++;
            $display("FAIL invalid_addr v=%0d: got %0d need %0d", v, addr0, 256 + v - 50);
          end
        end
      end
    end
  endtask

  task automatic test_scale();
    set_write(1, 7);
    step(30, 30);
    x_in = 11'd0;
    y_in = 10'd0;
    step(0, 0);
    for (int v = 0; v <= 6; v++) begin
      for (int h = 0; h <= 72; h++) begin
        step(h, v);
        vecs++;
        if ({addr0, pix0, act0, addr1, pix1, act1} !==
            {e_addr0, e_pix0, e_act0, e_addr1, e_pix1, e_act1}) begin
          miss++;
          $display("FAIL scale h=%0d v=%0d: got %0d/%b/%b %0d/%b/%b need %0d/%b/%b %0d/%b/%b",
                   h, v, addr0, pix0, act0, addr1, pix1, act1,
                   e_addr0, e_pix0, e_act0, e_addr1, e_pix1, e_act1);
        end
        if (v == 4 && h == 32) begin
          vecs++;
          if (addr1 !== 9'd114) begin
            miss++;
            $display("FAIL scale_addr: got %0d need 114", addr1);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int fx, fy;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NC; i++) begin
        set_write(i, int'($urandom_range(0, 19)));
        step(int'($urandom_range(1, 2047)), int'($urandom_range(1, 1023)));
      end
      if (f == 5) begin
        fx = 2040; fy = 1020;
      end else begin
        fx = int'($urandom_range(0, 1900));
        fy = int'($urandom_range(0, 990));
      end
      x_in = 11'(fx);
      y_in = 10'(fy);
      step(0, 0);
      for (int v = fy - 1; v <= fy + 12; v++) begin
        if (v < 0 || v > 1023) continue;
        if ($urandom_range(0, 3) == 0) set_write(int'($urandom_range(0, NC - 1)),
                                                 int'($urandom_range(0, 31)));
        for (int h = fx - 3; h <= fx + 60; h++) begin
          if (h < 0 || h > 2047 || (h == 0 && v == 0)) continue;
          step(h, v);
          vecs++;
          if ({addr0, pix0, act0, addr1, pix1, act1} !==
              {e_addr0, e_pix0, e_act0, e_addr1, e_pix1, e_act1}) begin
            miss++;
            $display("FAIL random f=%0d h=%0d v=%0d: got %0d/%b/%b %0d/%b/%b need %0d/%b/%b %0d/%b/%b",
                     f, h, v, addr0, pix0, act0, addr1, pix1, act1,
                     e_addr0, e_pix0, e_act0, e_addr1, e_pix1, e_act1);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    set_write(0, 0);
    step(3, 3);
    x_in = 11'd100;
    y_in = 10'd50;
    step(0, 0);
    for (int h = 96; h <= 140 && !found; h++) begin
      step(h, 50);
      if (pix0 === 1'b1) found = 1'b1;
    end
    vecs++;
    if (!found) begin
      miss++;
      $display("FAIL reset_mid_lit: got pixel_out never 1 within budget, need a lit pixel");
    end
    #2 rst_n_in = 1'b0;
    #1;
    vecs++;
    if ({addr0, pix0, act0, addr1, pix1, act1} !== 24'd0) begin
      miss++;
      $display("FAIL reset_mid: got a0=%0d p0=%b c0=%b a1=%0d p1=%b c1=%b, need all 0",
               addr0, pix0, act0, addr1, pix1, act1);
    end
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    model_reset();
    step(0, 0);
    for (int h = 96; h <= 140; h++) begin
      step(h, 50);
      vecs++;
      if ({addr0, pix0, act0, addr1, pix1, act1} !==
          {e_addr0, e_pix0, e_act0, e_addr1, e_pix1, e_act1} || pix0 !== 1'b0) begin
        miss++;
        $display("FAIL reset_mid_blank h=%0d: got %0d/%b/%b %0d/%b/%b need %0d/%b/%b %0d/%b/%b",
                 h, addr0, pix0, act0, addr1, pix1, act1,
                 e_addr0, e_pix0, e_act0, e_addr1, e_pix1, e_act1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom_tbl[i] = 16'($urandom);
    for (int i = 256; i < 272; i++) rom_tbl[i] = 16'h0000;
    rom_tbl[0] = 16'b0000011111100000;
    rst_n_in   = 1'b0;
    hcount_in  = 11'd5;
    vcount_in  = 10'd5;
    x_in       = 11'd0;
    y_in       = 10'd0;
    wr_en_in   = 1'b0;
    wr_idx_in  = 3'd0;
    wr_code_in = 5'd0;
    model_reset();
    #17;
    test_reset();
    rst_n_in = 1'b1;
    test_blank_frame();
    test_glyph_a();
    test_commit();
    test_invalid_code();
    test_scale();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
